table_sweep_checker: RTL and testbench

TABLE_SWEEP_CHECKER -- requirements
Module: table_sweep_checker

---
 rtl/table_sweep_checker.sv | 168 ++++++++++++++++
 tb/tb_table_sweep_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/table_sweep_checker.sv
// table_sweep_checker: walks all 64 {a,b} operand pairs of a 3x3-bit multiply
// lookup in order. Each returned result is compared against an internally
// computed product. The block records the mismatch count, the first failing pair,
// and a sticky error flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begins one sweep when sampled in IDLE
//   a, b       operands driven to the lookup stage (0 outside ISSUE)
//   enable     lookup read enable (ISSUE and DRAIN)
//   result     lookup product, valid LATENCY cycles after its operands
//   busy       sweep in progress (ISSUE and DRAIN)
//   done       one-cycle pulse once the final comparison has landed
//   err_count  mismatches in the current/last sweep, saturates at 64
//   first_err  {a,b} of the first mismatch, 0 if none
//   err_seen   set on the first mismatch of a sweep
//
// All outputs are registered, so they trail the state register by one cycle.
// The a/b output registers act as pipeline stage 0. The LATENCY-deep expectation
// pipe therefore lines up with a result that appears LATENCY cycles after a/b.
module table_sweep_checker #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       enable,
  input  logic [5:0] result,
  output logic       busy,
  output logic       done,
  output logic [6:0] err_count,
  output logic [5:0] first_err,
  output logic       err_seen
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned PROD_W = 6;
  localparam int unsigned TAG_W  = 2 * OP_W;
  localparam int unsigned CNT_W  = 7;
  localparam logic [CNT_W-1:0] ERR_MAX   = CNT_W'(64);
  localparam logic [TAG_W-1:0] LAST_PAIR = TAG_W'(63);
  localparam logic [TAG_W-1:0] DRAIN_END = TAG_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("table_sweep_checker: LATENCY must be 1..4");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              valid;
    logic [PROD_W-1:0] prod;
    logic [TAG_W-1:0]  tag;
  } pipe_t;

  state_t           state, state_n;
  logic [TAG_W-1:0] cnt, cnt_n;
  logic             issue_v;
  logic [PROD_W-1:0] prod_c;
  logic             mismatch_c;
  logic             start_acc_c;
  pipe_t            pipe [LATENCY];

  // State and pair/drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; cnt indexes pairs in ISSUE and counts cycles in DRAIN
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = ISSUE;
      end
      ISSUE: begin
        if (cnt == LAST_PAIR) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TAG_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_END) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TAG_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign start_acc_c = (state == IDLE) && start;

  // Registered lookup-side and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      issue_v <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a       <= (state == ISSUE) ? cnt[5:3] : '0;
      b       <= (state == ISSUE) ? cnt[2:0] : '0;
      issue_v <= (state == ISSUE);
      enable  <= (state == ISSUE) || (state == DRAIN);
      busy    <= (state == ISSUE) || (state == DRAIN);
      done    <= (state == DONE);
    end
  end

  assign prod_c = PROD_W'(a) * PROD_W'(b);

  // Expectation pipe: tail entry aligns with the result for the same pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pipe_t'({issue_v, prod_c, a, b});
      for (int i = 1; i < int'(LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mismatch_c = pipe[LATENCY-1].valid && (result != pipe[LATENCY-1].prod);

  // Error bookkeeping; cleared on an accepted start, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (start_acc_c) begin
      err_count <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (mismatch_c) begin
      if (err_count != ERR_MAX) err_count <= err_count + CNT_W'(1);
      if (!err_seen) begin
        first_err <= pipe[LATENCY-1].tag;
        err_seen  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_table_sweep_checker.sv
// Directed bench for table_sweep_checker: two instances (LATENCY 2 and 4), each
// fed by a behavioural lookup model whose fault mode is selectable. Expected
// sweep results are queued at start and popped when done is observed.
module tb_table_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start2, start4;
  logic [2:0] a2, b2, a4, b4;
  logic enable2, enable4, busy2, busy4, done2, done4;
  logic [5:0] result2, result4;
  logic [6:0] err_count2, err_count4;
  logic [5:0] first_err2, first_err4;
  logic err_seen2, err_seen4;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;
  logic use4   = 1'b0;

  logic [5:0] m2 [2];
  logic [5:0] m4 [4];

  logic [2:0] a_o, b_o;
  logic       enable_o, busy_o, done_o, err_seen_o;
  logic [6:0] err_count_o;
  logic [5:0] first_err_o;

  typedef struct {
    int         cnt;
    logic [5:0] first;
    logic       seen;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] pair_q[$];

  always #5 clk = ~clk;

  table_sweep_checker #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .enable(enable2),
    .result(result2), .busy(busy2), .done(done2), .err_count(err_count2),
    .first_err(first_err2), .err_seen(err_seen2)
  );

  table_sweep_checker #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .enable(enable4),
    .result(result4), .busy(busy4), .done(done4), .err_count(err_count4),
    .first_err(first_err4), .err_seen(err_seen4)
  );

  function automatic logic [5:0] model_f(input int md, input logic [2:0] x, input logic [2:0] y);
    logic [5:0] p;
    p = 6'(x) * 6'(y);
    if (md == 1 && x == 3'd6 && y == 3'd5) p = 6'd31;
    if (md == 2) p = 6'd0;
    return p;
  endfunction

  // Lookup models: result appears LATENCY cycles after the operands
  always @(posedge clk) begin
    m2[0] <= model_f(mode, a2, b2);
    m2[1] <= m2[0];
    m4[0] <= model_f(mode, a4, b4);
    for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
  end
  assign result2 = m2[1];
  assign result4 = m4[3];

  always_comb begin
    a_o         = use4 ? a4 : a2;
    b_o         = use4 ? b4 : b2;
    enable_o    = use4 ? enable4 : enable2;
    busy_o      = use4 ? busy4 : busy2;
    done_o      = use4 ? done4 : done2;
    err_count_o = use4 ? err_count4 : err_count2;
    first_err_o = use4 ? first_err4 : first_err2;
    err_seen_o  = use4 ? err_seen4 : err_seen2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (use4) start4 = v;
    else      start2 = v;
  endtask

  // One full sweep with pair-order, drain-length, done-timing and result checks
  task automatic sweep(input logic sel4, input int md, input int ecnt,
                       input logic [5:0] efirst, input logic eseen, input logic noisy);
    exp_t e;
    int   c;
    logic got;
    @(negedge clk);
    use4  = sel4;
    mode  = md;
    e.cnt = ecnt; e.first = efirst; e.seen = eseen; e.lat = sel4 ? 4 : 2;
    exp_q.push_back(e);
    for (int k = 0; k < 64; k++) pair_q.push_back(6'(k));
    drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    for (int k = 0; k < 64; k++) begin
      if (noisy && k == 10) drive_start(1'b1);
      if (noisy && k == 12) drive_start(1'b0);
      if (noisy && k == 60) drive_start(1'b1);
      @(posedge clk); #1;
      check("pair_order", {26'd0, a_o, b_o}, {26'd0, pair_q.pop_front()});
      check("enable_issue", enable_o, 1);
    end
    c = 64;
    got = 1'b0;
    while (!got && c < 90) begin
      @(posedge clk); #1;
      c++;
      if (done_o) got = 1'b1;
      else check("enable_drain", enable_o, 1);
    end
    e = exp_q.pop_front();
    check("done_seen", got, 1);
    check("done_cycle", c, 65 + e.lat);
    check("err_count", err_count_o, e.cnt);
    check("first_err", first_err_o, e.first);
    check("err_seen", err_seen_o, e.seen);
    check("busy_at_done", busy_o, 0);
    check("enable_at_done", enable_o, 0);
    if (noisy) drive_start(1'b0);
    @(posedge clk); #1;
    check("done_pulse_width", done_o, 0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", busy_o, 0);
    check("idle_ab", {26'd0, a_o, b_o}, 0);
    check("hold_err_count", err_count_o, e.cnt);
    check("hold_first_err", first_err_o, e.first);
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
    #3;
    check("rst_busy", busy2, 0);
    check("rst_enable", enable2, 0);
    check("rst_done", done2, 0);
    check("rst_err_count", err_count2, 0);
    check("rst_first_err", first_err2, 0);
    check("rst_err_seen", err_seen2, 0);
    check("rst_ab4", {26'd0, a4, b4}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ideal lookup, then single corrupted pair, then all-zero lookup
    sweep(1'b0, 0, 0, 6'd0, 1'b0, 1'b0);
    sweep(1'b0, 1, 1, 6'b110101, 1'b1, 1'b0);
    sweep(1'b0, 2, 49, 6'b001001, 1'b1, 1'b0);

    // start pulsed during ISSUE and held through DONE: one sweep only
    sweep(1'b0, 0, 0, 6'd0, 1'b0, 1'b1);

    // Reset mid-sweep at pair (3,4) with the all-zero lookup
    @(negedge clk);
    use4 = 1'b0; mode = 2;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("mid_pair", {26'd0, a2, b2}, 28);
    check("mid_err_count", err_count2, 15);
    check("mid_first_err", first_err2, 6'b001001);
    #2 rst = 1'b1;
    #1;
    check("arst_ab", {26'd0, a2, b2}, 0);
    check("arst_enable", enable2, 0);
    check("arst_busy", busy2, 0);
    check("arst_err_count", err_count2, 0);
    check("arst_first_err", first_err2, 0);
    check("arst_err_seen", err_seen2, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_no_done", done2, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("post_rst_no_done", done2, 0);
    end
    sweep(1'b0, 0, 0, 6'd0, 1'b0, 1'b0);

    // LATENCY=4 instance with matching 4-cycle lookup
    sweep(1'b1, 0, 0, 6'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
